// File: rtl/clk_seq_pkg.sv
// Shared definitions for the clock/reset sequencer:
// state encoding and a constant clog2 helper.
package clk_seq_pkg;

  localparam logic [2:0] PLL_RST   = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] STABLE    = 3'd2;
  localparam logic [2:0] RST_HOLD  = 3'd3;
  localparam logic [2:0] DAC_WAIT  = 3'd4;
  localparam logic [2:0] RUN       = 3'd5;
  localparam logic [2:0] LOST      = 3'd6;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v)
        r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow level signals
// crossing into the local clock domain.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/clk_rst_sequencer.sv
// Power-up / recovery sequencer: MMCM reset, lock
// qualification, datapath reset release, DAC clock enable.
module clk_rst_sequencer
  import clk_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 1048576,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_RELEASE_CYCLES = 64,
  parameter int DAC_EN_DELAY       = 64,
  parameter int CNT_W              = 8
) (
  input  logic             SYS_CLK,
  input  logic             A_GLB_RST_N,
  input  logic             LOCKED,
  input  logic             SOFT_RST,
  output logic             MMCM_RST,
  output logic             DP_RST_N,
  output logic             DAC_CLK_ENABLE,
  output logic             READY,
  output logic [2:0]       STATE,
  output logic [CNT_W-1:0] LOCK_LOSS_CNT
);

  localparam int M1 =
    (PLL_RST_CYCLES > LOCK_TIMEOUT) ?
    PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int M2 =
    (LOCK_STABLE_CYCLES > RST_RELEASE_CYCLES) ?
    LOCK_STABLE_CYCLES : RST_RELEASE_CYCLES;
  localparam int M3 = (M1 > M2) ? M1 : M2;
  localparam int MX = (M3 > DAC_EN_DELAY) ? M3 : DAC_EN_DELAY;
  localparam int CW = (clog2(MX) < 1) ? 1 : clog2(MX);

  localparam logic [CW-1:0] PLL_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] RH_LAST  = CW'(RST_RELEASE_CYCLES - 1);
  localparam logic [CW-1:0] DAC_LAST = CW'(DAC_EN_DELAY - 1);

  logic          lock_s;
  logic [2:0]    state;
  logic [2:0]    nxt;
  logic [CW-1:0] cnt;
  logic          restart;

  sync_2ff #(
    .W(1)
  ) u_lock_sync (
    .clk  (SYS_CLK),
    .rst_n(A_GLB_RST_N),
    .d    (LOCKED),
    .q    (lock_s)
  );

  always_comb begin
    nxt = state;
    if (SOFT_RST) begin
      nxt = PLL_RST;
    end else begin
      unique case (state)
        PLL_RST:
          if (cnt == PLL_LAST) nxt = WAIT_LOCK;
        WAIT_LOCK:
          if (lock_s)               nxt = STABLE;
          else if (cnt == TO_LAST)  nxt = PLL_RST;
        STABLE:
          if (!lock_s)              nxt = WAIT_LOCK;
          else if (cnt == STB_LAST) nxt = RST_HOLD;
        RST_HOLD:
          if (!lock_s)              nxt = LOST;
          else if (cnt == RH_LAST)  nxt = DAC_WAIT;
        DAC_WAIT:
          if (!lock_s)              nxt = LOST;
          else if (cnt == DAC_LAST) nxt = RUN;
        RUN:
          if (!lock_s)              nxt = LOST;
        default:
          nxt = PLL_RST;
      endcase
    end
  end

  // A soft restart from PLL_RST must still give a full pulse.
  assign restart = SOFT_RST || (nxt != state);

  always_ff @(posedge SYS_CLK or negedge A_GLB_RST_N) begin
    if (!A_GLB_RST_N) begin
      state          <= PLL_RST;
      cnt            <= '0;
      MMCM_RST       <= 1'b1;
      DP_RST_N       <= 1'b0;
      DAC_CLK_ENABLE <= 1'b0;
      READY          <= 1'b0;
      LOCK_LOSS_CNT  <= '0;
    end else begin
      state          <= nxt;
      MMCM_RST       <= (nxt == PLL_RST);
      DP_RST_N       <= (nxt == DAC_WAIT) || (nxt == RUN);
      DAC_CLK_ENABLE <= (nxt == RUN);
      READY          <= (nxt == RUN);
      if (restart)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + 1'b1;
      if (nxt == LOST && state != LOST &&
          LOCK_LOSS_CNT != {CNT_W{1'b1}})
        LOCK_LOSS_CNT <= LOCK_LOSS_CNT + 1'b1;
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Directed bench for clk_rst_sequencer; cycle k is
// sampled on the k-th falling edge after reset release.
module tb_clk_rst_sequencer;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       soft_rst;
  logic       mmcm_rst;
  logic       dp_rst_n;
  logic       dac_en;
  logic       ready;
  logic [2:0] state;
  logic [1:0] llc;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 sys_clk = ~sys_clk;

  clk_rst_sequencer #(
    .PLL_RST_CYCLES    (4),
    .LOCK_TIMEOUT      (100),
    .LOCK_STABLE_CYCLES(8),
    .RST_RELEASE_CYCLES(4),
    .DAC_EN_DELAY      (4),
    .CNT_W             (2)
  ) dut (
    .SYS_CLK       (sys_clk),
    .A_GLB_RST_N   (rst_n),
    .LOCKED        (locked),
    .SOFT_RST      (soft_rst),
    .MMCM_RST      (mmcm_rst),
    .DP_RST_N      (dp_rst_n),
    .DAC_CLK_ENABLE(dac_en),
    .READY         (ready),
    .STATE         (state),
    .LOCK_LOSS_CNT (llc)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, ".state"}, int'(state), 0);
    chk({tag, ".mmcm"},  int'(mmcm_rst), 1);
    chk({tag, ".dp"},    int'(dp_rst_n), 0);
    chk({tag, ".dac"},   int'(dac_en), 0);
    chk({tag, ".ready"}, int'(ready), 0);
    chk({tag, ".llc"},   int'(llc), 0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    locked   = 1'b0;
    soft_rst = 1'b0;
    adv(3);
    chk_rst_vals("in_reset");
    rst_n = 1'b1;
  endtask

  initial begin
    // clean bring-up, LOCKED rises at cycle 20
    do_reset();
    chk("bu.c0.mmcm", int'(mmcm_rst), 1);
    adv(3);
    chk("bu.c3.mmcm", int'(mmcm_rst), 1);
    adv(1);
    chk("bu.c4.mmcm", int'(mmcm_rst), 0);
    chk("bu.c4.state", int'(state), 1);
    adv(16);
    locked = 1'b1;
    adv(2);
    chk("bu.c22.state", int'(state), 1);
    adv(1);
    chk("bu.c23.state", int'(state), 2);
    adv(11);
    chk("bu.c34.dp", int'(dp_rst_n), 0);
    adv(1);
    chk("bu.c35.dp", int'(dp_rst_n), 1);
    chk("bu.c35.state", int'(state), 4);
    adv(3);
    chk("bu.c38.dac", int'(dac_en), 0);
    adv(1);
    chk("bu.c39.dac", int'(dac_en), 1);
    chk("bu.c39.ready", int'(ready), 1);
    chk("bu.c39.state", int'(state), 5);

    // lock loss in RUN at cycle 44
    adv(5);
    locked = 1'b0;
    adv(2);
    chk("ll.c46.ready", int'(ready), 1);
    adv(1);
    chk("ll.c47.ready", int'(ready), 0);
    chk("ll.c47.dac", int'(dac_en), 0);
    chk("ll.c47.dp", int'(dp_rst_n), 0);
    chk("ll.c47.state", int'(state), 6);
    chk("ll.c47.llc", int'(llc), 1);
    adv(1);
    chk("ll.c48.state", int'(state), 0);
    chk("ll.c48.mmcm", int'(mmcm_rst), 1);
    locked = 1'b1;
    adv(20);
    chk("ll.c68.ready", int'(ready), 0);
    chk("ll.c68.dp", int'(dp_rst_n), 1);
    adv(1);
    chk("ll.c69.ready", int'(ready), 1);
    chk("ll.c69.llc", int'(llc), 1);

    // SOFT_RST in the same cycle the FSM sees the loss
    adv(1);
    locked = 1'b0;
    adv(2);
    chk("sr.c72.ready", int'(ready), 1);
    soft_rst = 1'b1;
    adv(1);
    soft_rst = 1'b0;
    chk("sr.c73.state", int'(state), 0);
    chk("sr.c73.mmcm", int'(mmcm_rst), 1);
    chk("sr.c73.llc", int'(llc), 1);

    // lock timeout: PLL_RST 73..76, WAIT_LOCK 77..176
    adv(103);
    chk("to.c176.mmcm", int'(mmcm_rst), 0);
    chk("to.c176.state", int'(state), 1);
    adv(1);
    chk("to.c177.mmcm", int'(mmcm_rst), 1);
    adv(3);
    chk("to.c180.mmcm", int'(mmcm_rst), 1);
    adv(1);
    chk("to.c181.mmcm", int'(mmcm_rst), 0);
    adv(100);
    chk("to.c281.mmcm", int'(mmcm_rst), 1);
    chk("to.c281.llc", int'(llc), 1);

    // one-cycle glitch at stable cycle 5
    do_reset();
    adv(20);
    locked = 1'b1;
    adv(3);
    chk("gl.c23.state", int'(state), 2);
    adv(5);
    locked = 1'b0;
    adv(1);
    locked = 1'b1;
    adv(1);
    chk("gl.c30.state", int'(state), 2);
    adv(1);
    chk("gl.c31.state", int'(state), 1);
    adv(1);
    chk("gl.c32.state", int'(state), 2);
    adv(7);
    chk("gl.c39.state", int'(state), 2);
    adv(1);
    chk("gl.c40.state", int'(state), 3);
    adv(3);
    chk("gl.c43.dp", int'(dp_rst_n), 0);
    adv(1);
    chk("gl.c44.dp", int'(dp_rst_n), 1);
    chk("gl.c44.llc", int'(llc), 0);
    adv(4);
    chk("gl.c48.ready", int'(ready), 1);

    // five losses with a 2-bit counter
    for (int i = 1; i <= 5; i++) begin
      locked = 1'b0;
      adv(3);
      chk($sformatf("sat%0d.state", i), int'(state), 6);
      chk($sformatf("sat%0d.llc", i), int'(llc), (i > 3) ? 3 : i);
      locked = 1'b1;
      adv(22);
      chk($sformatf("sat%0d.ready", i), int'(ready), 1);
    end

    // async reset while in DAC_WAIT
    soft_rst = 1'b1;
    adv(1);
    soft_rst = 1'b0;
    adv(18);
    chk("ar.state_pre", int'(state), 4);
    chk("ar.dp_pre", int'(dp_rst_n), 1);
    #2 rst_n = 1'b0;
    #1 chk_rst_vals("async_rst");
    adv(1);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
